// File: rtl/fib_index_decoder.sv
// Classifies a WIDTH-bit value as a Fibonacci number, walking the sequence one term per clock.
// Optional continuity checker on hit indices is enabled with `define FIB_SEQ_CHECK_EN.
module fib_index_decoder #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned MAX_INDEX = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_index,
  output logic             seq_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_t;

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_INDEX);

  state_t r_state, w_state_nx;

  // One extra bit on a/b so the term after F(MAX_INDEX) never wraps.
  logic [WIDTH:0]   r_a, r_b, w_a_nx, w_b_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic [WIDTH-1:0] r_target, w_target_nx;
  logic             r_hit, w_hit_nx;
  logic [IDX_W-1:0] r_index, w_index_nx;
  logic [WIDTH:0]   w_target_ext;

  assign w_target_ext = {1'b0, r_target};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_a_nx      = r_a;
    w_b_nx      = r_b;
    w_idx_nx    = r_idx;
    w_target_nx = r_target;
    w_hit_nx    = r_hit;
    w_index_nx  = r_index;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_target_nx = in_value;
          w_a_nx      = '0;
          w_b_nx      = (WIDTH+1)'(1);
          w_idx_nx    = '0;
          w_state_nx  = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (r_a == w_target_ext) begin
          w_hit_nx   = 1'b1;
          w_index_nx = r_idx;
          w_state_nx = ST_DONE;
        end else if (r_a > w_target_ext) begin
          w_hit_nx   = 1'b0;
          w_index_nx = r_idx;
          w_state_nx = ST_DONE;
        end else if (r_idx == MAX_IDX) begin
          w_hit_nx   = 1'b0;
          w_index_nx = MAX_IDX;
          w_state_nx = ST_DONE;
        end else begin
          w_a_nx   = r_b;
          w_b_nx   = r_a + r_b;
          w_idx_nx = r_idx + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= (WIDTH+1)'(1);
      r_idx    <= '0;
      r_target <= '0;
      r_hit    <= 1'b0;
      r_index  <= '0;
    end else begin
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_idx    <= w_idx_nx;
      r_target <= w_target_nx;
      r_hit    <= w_hit_nx;
      r_index  <= w_index_nx;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_hit   = r_hit;
  assign out_index = r_index;

`ifdef FIB_SEQ_CHECK_EN
  logic [IDX_W-1:0] r_last_idx;
  logic             r_have_last;
  logic             r_seq_err;
  logic             w_xfer;
  logic [IDX_W-1:0] w_exp_idx;
  logic             w_dup_one;

  assign w_xfer    = out_valid && out_ready;
  assign w_exp_idx = (r_last_idx == MAX_IDX) ? '0 : r_last_idx + IDX_W'(1);
  // A repeated index 1 straight after index 1 is the second 1 of the sequence,
  // so it is legal and is recorded as index 2 to keep the next expectation right.
  assign w_dup_one = r_have_last && (r_last_idx == IDX_W'(1)) && (r_index == IDX_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_idx  <= '0;
      r_have_last <= 1'b0;
      r_seq_err   <= 1'b0;
    end else if (w_xfer) begin
      if (!r_hit) begin
        r_seq_err <= 1'b1;
      end else begin
        if (r_have_last && !w_dup_one && (r_index != w_exp_idx)) begin
          r_seq_err <= 1'b1;
        end
        r_last_idx  <= w_dup_one ? IDX_W'(2) : r_index;
        r_have_last <= 1'b1;
      end
    end
  end

  assign seq_err = r_seq_err;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_index_decoder.sv
// Directed bench for fib_index_decoder: vector table plus hand-written handshake and reset sequences.
module tb_fib_index_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_hit;
  logic [4:0]  out_index;
  logic        seq_err;

  int total = 0;
  int bad   = 0;

  fib_index_decoder #(
    .WIDTH    (12),
    .IDX_W    (5),
    .MAX_INDEX(14)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hit  (out_hit),
    .out_index(out_index),
    .seq_err  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] value;
    logic        hit;
    logic [4:0]  index;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One transaction with out_ready high; lat = edges from capture to out_valid seen.
  task automatic xact(input logic [11:0] v, output logic h, output logic [4:0] ix,
                      output int lat, output logic rdy_after);
    @(negedge clk);
    out_ready = 1'b1;
    in_value  = v;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    h  = out_hit;
    ix = out_index;
    @(negedge clk);
    rdy_after = in_ready && !out_valid;
  endtask

  initial begin
    vec_t vecs[13];
    logic h;
    logic [4:0] ix;
    int lat;
    logic rdy;
    int first_e, second_e;
    logic [4:0] first_ix, second_ix;
    logic first_h, second_h;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_value = '0;
    vecs[0]  = '{12'd0,    1'b1, 5'd0,  1};
    vecs[1]  = '{12'd1,    1'b1, 5'd1,  2};
    vecs[2]  = '{12'd2,    1'b1, 5'd3,  4};
    vecs[3]  = '{12'd3,    1'b1, 5'd4,  5};
    vecs[4]  = '{12'd13,   1'b1, 5'd7,  8};
    vecs[5]  = '{12'd144,  1'b1, 5'd12, 13};
    vecs[6]  = '{12'd377,  1'b1, 5'd14, 15};
    vecs[7]  = '{12'd4,    1'b0, 5'd5,  6};
    vecs[8]  = '{12'd6,    1'b0, 5'd6,  7};
    vecs[9]  = '{12'd100,  1'b0, 5'd12, 13};
    vecs[10] = '{12'd378,  1'b0, 5'd14, 15};
    vecs[11] = '{12'd610,  1'b0, 5'd14, 15};
    vecs[12] = '{12'd4095, 1'b0, 5'd14, 15};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_seq_err", seq_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      xact(vecs[i].value, h, ix, lat, rdy);
      chk($sformatf("hit[%0d]", vecs[i].value), h, vecs[i].hit);
      chk($sformatf("index[%0d]", vecs[i].value), ix, vecs[i].index);
      chk($sformatf("latency[%0d]", vecs[i].value), lat, vecs[i].lat);
      chk($sformatf("ready_after[%0d]", vecs[i].value), rdy, 1);
    end

    // Back-to-back: 13 then 21 with in_valid and out_ready held high.
    first_e = 0; second_e = 0;
    first_ix = '0; second_ix = '0; first_h = 1'b0; second_h = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_value = 12'd13;
    @(posedge clk);
    #1 in_value = 12'd21;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid && first_e == 0) begin
        first_e = c; first_h = out_hit; first_ix = out_index;
      end else if (out_valid && second_e == 0) begin
        second_e = c; second_h = out_hit; second_ix = out_index;
        break;
      end
    end
    in_valid = 1'b0;
    chk("b2b_first_edge", first_e, 8);
    chk("b2b_first_hit", first_h, 1);
    chk("b2b_first_index", first_ix, 7);
    chk("b2b_second_edge", second_e, 19);
    chk("b2b_second_hit", second_h, 1);
    chk("b2b_second_index", second_ix, 8);
    @(negedge clk);

    // Result held under backpressure; input offered meanwhile must be ignored.
    out_ready = 1'b0; in_value = 12'd1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk("hold_latency", lat, 2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 3);
      in_value = 12'd8;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_hit", out_hit, 1);
      chk("hold_out_index", out_index, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    chk("ignored_input_idle", in_ready, 1);
    chk("ignored_input_no_result", out_valid, 0);
`ifndef FIB_SEQ_CHECK_EN
    chk("seq_err_disabled", seq_err, 0);
`endif

    // Reset mid-search on 233.
    out_ready = 1'b0; in_value = 12'd233; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_searching", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_hit", out_hit, 0);
    chk("midrst_out_index", out_index, 0);
    chk("midrst_seq_err", seq_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);
    xact(12'd21, h, ix, lat, rdy);
    chk("postrst_index21", ix, 8);
    chk("postrst_lat21", lat, 9);

`ifdef FIB_SEQ_CHECK_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic [11:0] stream[16];
      stream = '{12'd0, 12'd1, 12'd1, 12'd2, 12'd3, 12'd5, 12'd8, 12'd13, 12'd21,
                 12'd34, 12'd55, 12'd89, 12'd144, 12'd233, 12'd377, 12'd0};
      for (int i = 0; i < 16; i++) begin
        xact(stream[i], h, ix, lat, rdy);
        chk($sformatf("stream_seq_err[%0d]", i), seq_err, 0);
      end
    end
    xact(12'd2, h, ix, lat, rdy);
    xact(12'd5, h, ix, lat, rdy);
    chk("seq_err_set", seq_err, 1);
    xact(12'd8, h, ix, lat, rdy);
    chk("seq_err_sticky", seq_err, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("seq_err_reset", seq_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
